// File: rtl/cdc_gray_rd_port.sv
// Read half of a Gray-pointer asynchronous FIFO, running entirely on dst_clk_i.
// Optional macro CDC_GRAY_RD_SPILL_EN inserts a one-entry output register after the FIFO head.
module cdc_gray_rd_port #(
  parameter type T           = logic,
  parameter int  LOG_DEPTH   = 1,
  parameter int  SYNC_STAGES = 2
) (
  input  logic               dst_clk_i,
  input  logic               dst_rst_ni,
  input  T                   async_data_i [2**LOG_DEPTH],
  input  logic [LOG_DEPTH:0] async_wptr_i,
  output logic [LOG_DEPTH:0] async_rptr_o,
  output T                   dst_data_o,
  output logic               dst_valid_o,
  input  logic               dst_ready_i,
  output logic [LOG_DEPTH:0] dst_fill_o
);

  typedef logic [LOG_DEPTH:0] ptr_t;

  if (LOG_DEPTH < 1) begin : g_bad_depth
    $error("cdc_gray_rd_port: LOG_DEPTH must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("cdc_gray_rd_port: SYNC_STAGES must be >= 2");
  end

  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[LOG_DEPTH] = g[LOG_DEPTH];
    for (int i = LOG_DEPTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  ptr_t wptr_sync_q [SYNC_STAGES];
  ptr_t wptr_sync;
  ptr_t rptr_bin_q, rptr_bin_d;
  ptr_t rptr_gray_q;
  ptr_t fifo_fill;
  logic fifo_valid;
  logic fifo_pop;

  // Write-pointer synchronizer; only the last stage is ever consumed.
  always_ff @(posedge dst_clk_i) begin
    if (!dst_rst_ni) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        wptr_sync_q[i] <= '0;
      end
    end else begin
      wptr_sync_q[0] <= async_wptr_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        wptr_sync_q[i] <= wptr_sync_q[i-1];
      end
    end
  end

  assign wptr_sync = wptr_sync_q[SYNC_STAGES-1];

  // rptr_gray_q always mirrors bin2gray(rptr_bin_q), so it doubles as the empty comparand.
  assign fifo_valid = (wptr_sync != rptr_gray_q);
  assign fifo_fill  = gray2bin(wptr_sync) - rptr_bin_q;
  assign rptr_bin_d = rptr_bin_q + {{LOG_DEPTH{1'b0}}, fifo_pop};

  // Read pointer, binary for addressing and Gray for the write domain.
  always_ff @(posedge dst_clk_i) begin
    if (!dst_rst_ni) begin
      rptr_bin_q  <= '0;
      rptr_gray_q <= '0;
    end else begin
      rptr_bin_q  <= rptr_bin_d;
      rptr_gray_q <= bin2gray(rptr_bin_d);
    end
  end

  assign async_rptr_o = rptr_gray_q;

`ifdef CDC_GRAY_RD_SPILL_EN
  T     spill_data_q, spill_data_d;
  logic spill_valid_q, spill_valid_d;
  logic spill_load;

  // The register refills from the FIFO whenever it is empty or being drained.
  always_comb begin
    spill_load    = ~spill_valid_q | dst_ready_i;
    fifo_pop      = fifo_valid & spill_load;
    spill_valid_d = spill_valid_q;
    spill_data_d  = spill_data_q;
    if (spill_load) begin
      spill_valid_d = fifo_valid;
      spill_data_d  = async_data_i[rptr_bin_q[LOG_DEPTH-1:0]];
    end else begin
      spill_valid_d = spill_valid_q;
      spill_data_d  = spill_data_q;
    end
  end

  // Output register state.
  always_ff @(posedge dst_clk_i) begin
    if (!dst_rst_ni) begin
      spill_valid_q <= 1'b0;
      spill_data_q  <= '0;
    end else begin
      spill_valid_q <= spill_valid_d;
      spill_data_q  <= spill_data_d;
    end
  end

  assign dst_valid_o = spill_valid_q;
  assign dst_data_o  = spill_data_q;
  assign dst_fill_o  = fifo_fill + {{LOG_DEPTH{1'b0}}, spill_valid_q};
`else
  assign fifo_pop    = fifo_valid & dst_ready_i;
  assign dst_valid_o = fifo_valid;
  assign dst_data_o  = async_data_i[rptr_bin_q[LOG_DEPTH-1:0]];
  assign dst_fill_o  = fifo_fill;
`endif

endmodule
